// File: rtl/ecc_pkg.sv
// SECDED helpers shared by the encoder and the decode pipeline:
// check-bit width, H-matrix column generator and error classification codes.
package ecc_pkg;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] SBIT = 2'd1;
  localparam logic [1:0] DBIT = 2'd2;

  // Check-bit count: Hamming r (smallest with 2^r >= dw+r+1) plus one overall bit.
  function automatic int pw_calc(input int dw);
    int r;
    r = 0;
    for (int k = 1; k <= 9; k++)
      if (r == 0 && (1 << k) >= dw + k + 1) r = k;
    return r + 1;
  endfunction

  // Column for data bit i: the (i+1)-th non-power-of-two >= 3 in the low r bits,
  // with bit r set when needed so every data column has odd weight.
  function automatic logic [31:0] h_col(input int i, input int r);
    int k;
    logic [31:0] col;
    k   = 0;
    col = '0;
    for (int v = 3; k <= i; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (k == i) col = 32'(v);
        k++;
      end
    end
    if (^col == 1'b0) col = col | (32'd1 << r);
    return col;
  endfunction

endpackage

// File: rtl/ecc_secded_enc.sv
// Combinational SECDED check-bit generator: parity[j] is the XOR of all data
// bits whose H column has bit j set.
module ecc_secded_enc
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 22
) (
  input  logic [DATA_WIDTH-1:0]            data,
  output logic [pw_calc(DATA_WIDTH)-1:0]   parity
);

  localparam int PW = pw_calc(DATA_WIDTH);

  // mask[j] selects the data bits that feed check bit j
  logic [PW-1:0][DATA_WIDTH-1:0] mask;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
    localparam logic [31:0] COL = h_col(i, PW - 1);
    for (genvar j = 0; j < PW; j++) begin : g_bit
      assign mask[j][i] = COL[j];
    end
  end

  for (genvar j = 0; j < PW; j++) begin : g_par
    assign parity[j] = ^(data & mask[j]);
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED decode pipeline with write-path encoder, error counters,
// first-error log and double-bit interrupt pulse.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 22,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           enc_data,
  output logic [pw_calc(DATA_WIDTH)-1:0]  enc_parity,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [pw_calc(DATA_WIDTH)-1:0]  in_parity,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  input  logic                            in_bypass,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic                            out_sbit_err,
  output logic                            out_dbit_err,
  output logic [CNT_WIDTH-1:0]            sbit_cnt,
  output logic [CNT_WIDTH-1:0]            dbit_cnt,
  input  logic                            cnt_clr,
  output logic                            log_valid,
  output logic [TAG_WIDTH-1:0]            log_tag,
  output logic [pw_calc(DATA_WIDTH)-1:0]  log_syndrome,
  output logic                            log_dbit,
  input  logic                            log_clr,
  output logic                            irq_dbit
);

  localparam int PW = pw_calc(DATA_WIDTH);

  logic [PW-1:0]         rd_parity;
  logic                  adv, fire, capture;
  logic [2:1]            vld_pipe;
  logic [DATA_WIDTH-1:0] s1_data, dec_data;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s1_bypass;
  logic [PW-1:0]         s1_syn, out_syn;
  logic [DATA_WIDTH-1:0] match;
  logic [1:0]            dec_code;

  ecc_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc_wr (.data(enc_data), .parity(enc_parity));
  ecc_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc_rd (.data(in_data),  .parity(rd_parity));

  // Whole pipe moves together; it only stalls when the output word is held.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[2];
  assign fire      = out_valid && out_ready;

  // One comparator per data bit: which column (if any) the syndrome names
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_match
    localparam logic [31:0] COL = h_col(i, PW - 1);
    assign match[i] = (s1_syn == COL[PW-1:0]);
  end

  // Classify the stage-1 syndrome and correct a single data-bit error
  always_comb begin
    dec_data = s1_data;
    dec_code = NONE;
    if (!s1_bypass && s1_syn != '0) begin
      if (|match) begin
        dec_data = s1_data ^ match;
        dec_code = SBIT;
      end else if ($onehot(s1_syn)) begin
        dec_code = SBIT;
      end else begin
        dec_code = DBIT;
      end
    end
  end

  // Control state of both stages: valid bits and output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      out_sbit_err <= 1'b0;
      out_dbit_err <= 1'b0;
    end else if (adv) begin
      vld_pipe     <= {vld_pipe[1], in_valid};
      out_sbit_err <= (dec_code == SBIT);
      out_dbit_err <= (dec_code == DBIT);
    end
  end

  // Payload registers of both stages; contents are don't-care while invalid
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_data   <= in_data;
      s1_tag    <= in_tag;
      s1_bypass <= in_bypass;
      s1_syn    <= in_parity ^ rd_parity;
      out_data  <= dec_data;
      out_tag   <= s1_tag;
      out_syn   <= s1_syn;
    end
  end

  // Saturating error counters, counted once per output handshake; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (cnt_clr) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else begin
      if (fire && out_sbit_err && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (fire && out_dbit_err && dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
    end
  end

  // Capture into an empty (or just-cleared) log, or let a dbit word replace an sbit entry
  assign capture = fire && (out_sbit_err || out_dbit_err) &&
                   (!log_valid || log_clr || (out_dbit_err && !log_dbit));

  // First-error log
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_valid    <= 1'b0;
      log_tag      <= '0;
      log_syndrome <= '0;
      log_dbit     <= 1'b0;
    end else if (capture) begin
      log_valid    <= 1'b1;
      log_tag      <= out_tag;
      log_syndrome <= out_syn;
      log_dbit     <= out_dbit_err;
    end else if (log_clr) begin
      log_valid    <= 1'b0;
      log_dbit     <= 1'b0;
    end
  end

  // One-cycle interrupt after a double-bit word leaves the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_dbit <= 1'b0;
    else     irq_dbit <= fire && out_dbit_err;
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe (DATA_WIDTH=22, CNT_WIDTH=2) with
// hand-computed syndromes and expected outputs.
module tb_ecc_secded_pipe;

  localparam int DW = 22;
  localparam int TW = 8;
  localparam int CW = 2;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] enc_data;
  logic [PW-1:0] enc_parity;
  logic          in_valid, in_ready, in_bypass;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_parity;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_sbit_err, out_dbit_err;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic          cnt_clr, log_valid, log_dbit, log_clr, irq_dbit;
  logic [TW-1:0] log_tag;
  logic [PW-1:0] log_syndrome;

  int n_chk  = 0;
  int n_pass = 0;

  ecc_secded_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .enc_data(enc_data), .enc_parity(enc_parity),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .in_tag(in_tag), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .cnt_clr(cnt_clr),
    .log_valid(log_valid), .log_tag(log_tag), .log_syndrome(log_syndrome),
    .log_dbit(log_dbit), .log_clr(log_clr), .irq_dbit(irq_dbit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single cycle; afterwards it sits in stage 1
  task automatic put(input logic [DW-1:0] d, input logic [PW-1:0] p,
                     input logic [TW-1:0] t, input logic b);
    in_valid = 1'b1; in_data = d; in_parity = p; in_tag = t; in_bypass = b;
    tick();
    in_valid = 1'b0; in_bypass = 1'b0;
  endtask

  logic [TW-1:0] seen [8];
  int idx, got;
  logic acc, hs;

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; in_parity = '0; in_tag = '0;
    in_bypass = 0; out_ready = 1; cnt_clr = 0; log_clr = 0; enc_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sbit_cnt", sbit_cnt, 0);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_irq", irq_dbit, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // write-path encoder
    enc_data = 22'h000000; #1; chk("enc_zero", enc_parity, 6'b000000);
    enc_data = 22'h000001; #1; chk("enc_bit0", enc_parity, 6'b100011);
    enc_data = 22'h000003; #1; chk("enc_bit01", enc_parity, 6'b000110);
    enc_data = 22'h200000; #1; chk("enc_bit21", enc_parity, 6'b111011);

    // clean word, latency exactly 2
    put(22'h0, 6'b0, 8'd1, 1'b0);
    chk("lat1_valid", out_valid, 0);
    tick();
    chk("clean_valid", out_valid, 1);
    chk("clean_data", out_data, 0);
    chk("clean_sbit", out_sbit_err, 0);
    chk("clean_dbit", out_dbit_err, 0);
    chk("clean_tag", out_tag, 1);
    tick();
    chk("clean_drain", out_valid, 0);

    // single data-bit error on bit 0
    put(22'h000001, 6'b0, 8'd2, 1'b0);
    tick();
    chk("sbit_data", out_data, 0);
    chk("sbit_flag", out_sbit_err, 1);
    chk("sbit_nodbit", out_dbit_err, 0);
    tick();
    chk("sbit_cnt1", sbit_cnt, 1);
    chk("sbit_log_valid", log_valid, 1);
    chk("sbit_log_syn", log_syndrome, 6'b100011);
    chk("sbit_log_tag", log_tag, 2);
    chk("sbit_log_dbit", log_dbit, 0);

    // double error: bits 0 and 1
    put(22'h000003, 6'b0, 8'd3, 1'b0);
    tick();
    chk("dbit_flag", out_dbit_err, 1);
    chk("dbit_nosbit", out_sbit_err, 0);
    chk("dbit_data", out_data, 22'h000003);
    chk("dbit_irq_early", irq_dbit, 0);
    tick();
    chk("dbit_irq", irq_dbit, 1);
    chk("dbit_cnt1", dbit_cnt, 1);
    chk("dbit_log_syn", log_syndrome, 6'b000110);
    chk("dbit_log_tag", log_tag, 3);
    chk("dbit_log_dbit", log_dbit, 1);
    tick();
    chk("dbit_irq_pulse", irq_dbit, 0);

    // check-bit error: data unchanged, log held on the dbit entry
    put(22'h0, 6'b000001, 8'd4, 1'b0);
    tick();
    chk("cbit_flag", out_sbit_err, 1);
    chk("cbit_data", out_data, 0);
    tick();
    chk("cbit_cnt2", sbit_cnt, 2);
    chk("cbit_log_hold", log_tag, 3);

    // bypass a corrupted word: passes raw, no flags, no counting
    put(22'h000001, 6'b0, 8'd5, 1'b1);
    tick();
    chk("byp_data", out_data, 22'h000001);
    chk("byp_sbit", out_sbit_err, 0);
    chk("byp_dbit", out_dbit_err, 0);
    tick();
    chk("byp_sbit_cnt", sbit_cnt, 2);
    chk("byp_dbit_cnt", dbit_cnt, 1);
    chk("byp_irq", irq_dbit, 0);

    // stall: 4 words, out_ready low for the first 5 cycles
    idx = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head_tag", out_tag, 10);
      end
      out_ready = (c >= 5);
      in_valid  = (idx < 4);
      in_tag    = 8'(10 + idx);
      in_data   = '0;
      in_parity = '0;
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (got < 8) seen[got] = out_tag;
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 0; out_ready = 1;
    chk("stall_count", got, 4);
    for (int k = 0; k < 4; k++) chk("stall_order", seen[k], 10 + k);

    // saturation with CNT_WIDTH=2
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("clr_sbit", sbit_cnt, 0);
    chk("clr_dbit", dbit_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_data = 22'h000001; in_parity = '0; in_tag = 8'(30 + k);
      tick();
    end
    in_valid = 0;
    tick(); tick(); tick();
    chk("sat_sbit", sbit_cnt, 3);
    chk("sat_log_hold", log_tag, 3);

    // event coincident with cnt_clr is dropped
    put(22'h000001, 6'b0, 8'd36, 1'b0);
    tick();
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("clr_drop", sbit_cnt, 0);

    // log_clr with a flagged word: clear then capture
    put(22'h000001, 6'b0, 8'd7, 1'b0);
    tick();
    log_clr = 1; tick(); log_clr = 0;
    chk("logclr_valid", log_valid, 1);
    chk("logclr_tag", log_tag, 7);
    chk("logclr_dbit", log_dbit, 0);
    chk("logclr_syn", log_syndrome, 6'b100011);
    chk("logclr_cnt", sbit_cnt, 1);
    log_clr = 1; tick(); log_clr = 0;
    chk("logclr_empty", log_valid, 0);

    // reset mid-stream
    in_valid = 1; in_data = 22'h000003; in_parity = '0; in_tag = 8'd20;
    tick();
    in_tag = 8'd21;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 0; rst = 1; #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sbit", sbit_cnt, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    tick();
    rst = 0;
    tick();
    chk("post_rst_valid", out_valid, 0);
    tick();
    chk("post_rst_valid2", out_valid, 0);
    chk("post_rst_dbit", dbit_cnt, 0);
    chk("post_rst_irq", irq_dbit, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
